// File: rtl/ahb_front_port_slice.sv
// ahb_front_port_slice
//
// AHB-Lite register slice placed directly in front of the AHB front-port-to-TileLink bridge.
// Every upstream NONSEQ/SEQ transfer is captured and re-issued downstream as a single
// NONSEQ/SINGLE transfer from registers, which cuts all combinational paths between the SoC
// bus and the bridge. A transfer costs two upstream wait states, plus one for every bridge
// wait state. At most one transfer is ever outstanding on the downstream port.
//
// Ports
//   clock, reset_n      block clock (rising edge) and asynchronous active-low reset
//   s_h*                upstream AHB-Lite slave port (from the external master)
//                       s_hburst is ignored; bursts are split into singles
//   m_h*                downstream AHB-Lite master port (into the bridge)
//                       m_hburst is always SINGLE, m_hready mirrors m_hreadyout
module ahb_front_port_slice #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  // Upstream slave port
  input  logic              s_hsel,
  input  logic [ADDR_W-1:0] s_haddr,
  input  logic [1:0]        s_htrans,
  input  logic              s_hwrite,
  input  logic [2:0]        s_hsize,
  input  logic [2:0]        s_hburst,
  input  logic [3:0]        s_hprot,
  input  logic              s_hmastlock,
  input  logic              s_hready,
  input  logic [DATA_W-1:0] s_hwdata,
  output logic              s_hreadyout,
  output logic              s_hresp,
  output logic [DATA_W-1:0] s_hrdata,
  // Downstream master port
  output logic              m_hsel,
  output logic [ADDR_W-1:0] m_haddr,
  output logic [1:0]        m_htrans,
  output logic              m_hwrite,
  output logic [2:0]        m_hsize,
  output logic [2:0]        m_hburst,
  output logic [3:0]        m_hprot,
  output logic              m_hmastlock,
  output logic              m_hready,
  output logic [DATA_W-1:0] m_hwdata,
  input  logic              m_hreadyout,
  input  logic              m_hresp,
  input  logic [DATA_W-1:0] m_hrdata
);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StData,
    StDone,
    StErr1,
    StErr2
  } state_e;

  state_e state_q, state_d;

  // Latched address-phase controls of the transfer being forwarded.
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [2:0]        size_q, size_d;
  logic [3:0]        prot_q, prot_d;
  logic              lock_q, lock_d;

  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Output flops decoded from the next state so every port is driven straight from a register.
  logic issue_q, issue_d;
  logic ready_q, ready_d;
  logic resp_q, resp_d;

  logic accept;
  logic take;

  // HTRANS[0] only separates NONSEQ from SEQ and BUSY from IDLE; neither matters here.
  logic unused_inputs;
  assign unused_inputs = ^{s_hburst, s_htrans[0]};

  assign accept = s_hsel & s_htrans[1] & s_hready;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    take    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          take    = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        // The upstream data phase overlaps ISSUE, so keep sampling until the bridge moves on.
        wdata_d = s_hwdata;
        if (m_hreadyout) begin
          state_d = StData;
        end
      end
      StData: begin
        // The first cycle of a two-cycle error has m_hreadyout low and is treated as a wait.
        if (m_hreadyout) begin
          if (m_hresp) begin
            state_d = StErr1;
          end else begin
            rdata_d = m_hrdata;
            state_d = StDone;
          end
        end
      end
      StDone, StErr2: begin
        if (accept) begin
          take    = 1'b1;
          state_d = StIssue;
        end else begin
          state_d = StIdle;
        end
      end
      StErr1: begin
        state_d = StErr2;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Address-phase capture
  always_comb begin
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    prot_d  = prot_q;
    lock_d  = lock_q;
    if (take) begin
      addr_d  = s_haddr;
      write_d = s_hwrite;
      size_d  = s_hsize;
      prot_d  = s_hprot;
      lock_d  = s_hmastlock;
    end
  end

  // Registered output decode
  always_comb begin
    issue_d = (state_d == StIssue);
    ready_d = (state_d == StIdle) | (state_d == StDone) | (state_d == StErr2);
    resp_d  = (state_d == StErr1) | (state_d == StErr2);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
      prot_q  <= '0;
      lock_q  <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      issue_q <= 1'b0;
      ready_q <= 1'b1;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
      prot_q  <= prot_d;
      lock_q  <= lock_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      issue_q <= issue_d;
      ready_q <= ready_d;
      resp_q  <= resp_d;
    end
  end

  // Upstream outputs
  assign s_hreadyout = ready_q;
  assign s_hresp     = resp_q;
  assign s_hrdata    = rdata_q;

  // Downstream outputs
  assign m_hsel      = issue_q;
  assign m_htrans    = {issue_q, 1'b0};
  assign m_haddr     = addr_q;
  assign m_hwrite    = write_q;
  assign m_hsize     = size_q;
  assign m_hburst    = 3'b000;
  assign m_hprot     = prot_q;
  assign m_hmastlock = lock_q;
  assign m_hwdata    = wdata_q;
  assign m_hready    = m_hreadyout;

endmodule

// File: tb/tb_ahb_front_port_slice.sv
// Self-checking bench for ahb_front_port_slice: a pipelined upstream master, a bridge-side slave
// with per-transfer wait/error programming, and a transfer-level reference model.
module tb_ahb_front_port_slice;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              s_hsel, s_hwrite, s_hmastlock, s_hready, s_hreadyout, s_hresp;
  logic [ADDR_W-1:0] s_haddr;
  logic [1:0]        s_htrans;
  logic [2:0]        s_hsize, s_hburst;
  logic [3:0]        s_hprot;
  logic [DATA_W-1:0] s_hwdata, s_hrdata;
  logic              m_hsel, m_hwrite, m_hmastlock, m_hready, m_hreadyout, m_hresp;
  logic [ADDR_W-1:0] m_haddr;
  logic [1:0]        m_htrans;
  logic [2:0]        m_hsize, m_hburst;
  logic [3:0]        m_hprot;
  logic [DATA_W-1:0] m_hwdata, m_hrdata;

  always #5 clock = ~clock;

  // Only slave on the upstream bus.
  assign s_hready = s_hreadyout;

  ahb_front_port_slice #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .s_hsel     (s_hsel),
    .s_haddr    (s_haddr),
    .s_htrans   (s_htrans),
    .s_hwrite   (s_hwrite),
    .s_hsize    (s_hsize),
    .s_hburst   (s_hburst),
    .s_hprot    (s_hprot),
    .s_hmastlock(s_hmastlock),
    .s_hready   (s_hready),
    .s_hwdata   (s_hwdata),
    .s_hreadyout(s_hreadyout),
    .s_hresp    (s_hresp),
    .s_hrdata   (s_hrdata),
    .m_hsel     (m_hsel),
    .m_haddr    (m_haddr),
    .m_htrans   (m_htrans),
    .m_hwrite   (m_hwrite),
    .m_hsize    (m_hsize),
    .m_hburst   (m_hburst),
    .m_hprot    (m_hprot),
    .m_hmastlock(m_hmastlock),
    .m_hready   (m_hready),
    .m_hwdata   (m_hwdata),
    .m_hreadyout(m_hreadyout),
    .m_hresp    (m_hresp),
    .m_hrdata   (m_hrdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [2:0]  size;
    logic [3:0]  prot;
    logic        lock;
    logic        seq;
    int          waits;
    logic        err;
  } xfer_t;

  typedef struct {
    int   waits;
    logic err;
  } cfg_t;

  typedef struct {
    logic [31:0] rdata;
    logic        resp;
    int          nw;
    logic        pre;
  } res_t;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [2:0]  size;
    logic [3:0]  prot;
    logic        lock;
    logic        stable;
  } log_t;

  xfer_t       xq[$];
  cfg_t        br_cfg_q[$];
  log_t        br_log[$];
  logic [31:0] br_mem[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];

  int burst_bad = 0, htrans_bad = 0, overlap_bad = 0, hready_bad = 0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic xfer_t mk(input logic [31:0] a, input logic w, input logic [31:0] d,
                               input logic sq, input int wt, input logic e);
    xfer_t x;
    x.addr  = a;
    x.write = w;
    x.wdata = d;
    x.size  = 3'd2;
    x.prot  = 4'b0011;
    x.lock  = 1'b0;
    x.seq   = sq;
    x.waits = wt;
    x.err   = e;
    return x;
  endfunction

  // ---------------------------------------------------------------------------------------------
  // Bridge-side slave: programmable wait states and two-cycle ERROR, logs every transfer it sees.
  // ---------------------------------------------------------------------------------------------
  logic        dp_active, dp_first, dp_stable, dp_err, dp_err1, dp_write, dp_lock;
  int          dp_wait;
  logic [31:0] dp_addr, dp_wd0;
  logic [2:0]  dp_size;
  logic [3:0]  dp_prot;
  cfg_t        br_c;

  initial begin
    m_hreadyout = 1'b1;
    m_hresp     = 1'b0;
    m_hrdata    = '0;
    dp_active   = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        dp_active   = 1'b0;
        m_hreadyout = 1'b1;
        m_hresp     = 1'b0;
      end else begin
        if (m_hready !== m_hreadyout) hready_bad++;
        if (m_hburst !== 3'b000) burst_bad++;
        if (m_htrans !== 2'b00 && m_htrans !== 2'b10) htrans_bad++;
        if (dp_active && m_htrans[1]) overlap_bad++;
        if (dp_active) begin
          if (dp_first) begin
            dp_wd0   = m_hwdata;
            dp_first = 1'b0;
          end else if (m_hwdata !== dp_wd0) begin
            dp_stable = 1'b0;
          end
          if (dp_wait > 0) begin
            m_hreadyout = 1'b0;
            m_hresp     = 1'b0;
            dp_wait--;
          end else if (dp_err && !dp_err1) begin
            m_hreadyout = 1'b0;
            m_hresp     = 1'b1;
            dp_err1     = 1'b1;
          end else begin
            m_hreadyout = 1'b1;
            m_hresp     = dp_err;
            if (dp_write) m_hrdata = $urandom;
            else m_hrdata = br_mem.exists(dp_addr) ? br_mem[dp_addr] : init_word(dp_addr);
            if (dp_write && !dp_err) br_mem[dp_addr] = m_hwdata;
            br_log.push_back('{dp_addr, dp_write, m_hwdata, dp_size, dp_prot, dp_lock, dp_stable});
            dp_active = 1'b0;
          end
        end else begin
          m_hreadyout = 1'b1;
          m_hresp     = 1'b0;
        end
        if (m_hsel && m_htrans[1] && m_hreadyout) begin
          if (br_cfg_q.size() > 0) br_c = br_cfg_q.pop_front();
          else br_c = '{0, 1'b0};
          dp_active = 1'b1;
          dp_first  = 1'b1;
          dp_stable = 1'b1;
          dp_wait   = br_c.waits;
          dp_err    = br_c.err;
          dp_err1   = 1'b0;
          dp_addr   = m_haddr;
          dp_write  = m_hwrite;
          dp_size   = m_hsize;
          dp_prot   = m_hprot;
          dp_lock   = m_hmastlock;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Pipelined upstream master running xq, scored against the transfer-level model.
  // Model: OKAY costs 2 + bridge waits; ERROR costs 4 + bridge waits and returns resp=1.
  // ---------------------------------------------------------------------------------------------
  task automatic run_seq(input string tag);
    res_t        res[$];
    int          n, log0, nw, exp_nw;
    logic        done, pre;
    xfer_t       e;
    log_t        lg;
    logic [31:0] exp_rd;
    n    = xq.size();
    log0 = br_log.size();
    foreach (xq[k]) br_cfg_q.push_back('{xq[k].waits, xq[k].err});
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        s_hsel      = 1'b1;
        s_htrans    = xq[i].seq ? 2'b11 : 2'b10;
        s_haddr     = xq[i].addr;
        s_hwrite    = xq[i].write;
        s_hsize     = xq[i].size;
        s_hprot     = xq[i].prot;
        s_hmastlock = xq[i].lock;
      end else begin
        s_hsel   = 1'b0;
        s_htrans = 2'b00;
      end
      s_hwdata = (i > 0) ? xq[i-1].wdata : $urandom;
      nw   = 0;
      done = 1'b0;
      pre  = 1'b0;
      for (int c = 0; c < 64 && !done; c++) begin
        @(negedge clock);
        if (s_hreadyout === 1'b1) begin
          done = 1'b1;
        end else begin
          nw++;
          pre = s_hresp;
        end
      end
      if (!done) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s[%0d] timeout: s_hreadyout stuck at %b, required 1", tag, i, s_hreadyout);
      end
      if (i > 0) res.push_back('{s_hrdata, s_hresp, nw, pre});
      @(posedge clock);
      #1;
    end

    for (int i = 0; i < n; i++) begin
      e      = xq[i];
      exp_nw = 2 + e.waits + (e.err ? 2 : 0);
      n_checks++;
      if (res[i].nw !== exp_nw) begin
        n_fail++;
        $display("FAIL %s[%0d] wait states: got %0d, required %0d", tag, i, res[i].nw, exp_nw);
      end
      n_checks++;
      if (res[i].resp !== e.err || res[i].pre !== e.err) begin
        n_fail++;
        $display("FAIL %s[%0d] hresp final/last-wait: got %b/%b, required %b/%b", tag, i,
                 res[i].resp, res[i].pre, e.err, e.err);
      end
      if (!e.write && !e.err) begin
        exp_rd = ref_mem.exists(e.addr) ? ref_mem[e.addr] : init_word(e.addr);
        n_checks++;
        if (res[i].rdata !== exp_rd) begin
          n_fail++;
          $display("FAIL %s[%0d] hrdata @%h: got %h, required %h", tag, i, e.addr, res[i].rdata,
                   exp_rd);
        end
      end
      if (e.write && !e.err) ref_mem[e.addr] = e.wdata;
    end

    n_checks++;
    if (br_log.size() - log0 !== n) begin
      n_fail++;
      $display("FAIL %s bridge transfer count: got %0d, required %0d", tag, br_log.size() - log0,
               n);
    end else begin
      for (int i = 0; i < n; i++) begin
        e  = xq[i];
        lg = br_log[log0 + i];
        n_checks++;
        if ({lg.addr, lg.write, lg.size, lg.prot, lg.lock} !==
            {e.addr, e.write, e.size, e.prot, e.lock}) begin
          n_fail++;
          $display("FAIL %s[%0d] m address phase: got %h w%b s%0d p%h l%b, required %h w%b s%0d p%h l%b",
                   tag, i, lg.addr, lg.write, lg.size, lg.prot, lg.lock,
                   e.addr, e.write, e.size, e.prot, e.lock);
        end
        if (e.write) begin
          n_checks++;
          if (lg.wdata !== e.wdata || lg.stable !== 1'b1) begin
            n_fail++;
            $display("FAIL %s[%0d] m_hwdata: got %h stable=%b, required %h stable=1", tag, i,
                     lg.wdata, lg.stable, e.wdata);
          end
        end
      end
    end
    n_checks++;
    if (burst_bad + htrans_bad + overlap_bad + hready_bad !== 0) begin
      n_fail++;
      $display("FAIL %s m protocol: burst=%0d htrans=%0d overlap=%0d hready=%0d, required all 0",
               tag, burst_bad, htrans_bad, overlap_bad, hready_bad);
    end
  endtask

  task automatic idle_inputs();
    s_hsel      = 1'b0;
    s_haddr     = '0;
    s_htrans    = 2'b00;
    s_hwrite    = 1'b0;
    s_hsize     = 3'd2;
    s_hburst    = 3'b000;
    s_hprot     = 4'b0011;
    s_hmastlock = 1'b0;
    s_hwdata    = '0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    n_checks++;
    if ({s_hreadyout, s_hresp, s_hrdata, m_hsel, m_htrans, m_haddr, m_hwdata} !==
        {1'b1, 1'b0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset values: rdy=%b resp=%b rdata=%h msel=%b mtrans=%b maddr=%h mwdata=%h",
               s_hreadyout, s_hresp, s_hrdata, m_hsel, m_htrans, m_haddr, m_hwdata);
    end
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    n_checks++;
    if ({s_hreadyout, s_hresp, m_htrans, m_hburst} !== {1'b1, 1'b0, 2'b00, 3'b000}) begin
      n_fail++;
      $display("FAIL post-reset idle: rdy=%b resp=%b mtrans=%b mburst=%b, required 1 0 00 000",
               s_hreadyout, s_hresp, m_htrans, m_hburst);
    end
    @(posedge clock);
    #1;
  endtask

  // Cycle-exact single read through a zero-wait bridge.
  task automatic test_single_read();
    br_mem[32'h2000_0010]  = 32'hDEAD_BEEF;
    ref_mem[32'h2000_0010] = 32'hDEAD_BEEF;
    br_cfg_q.push_back('{0, 1'b0});
    s_hsel   = 1'b1;
    s_htrans = 2'b10;
    s_haddr  = 32'h2000_0010;
    s_hwrite = 1'b0;
    @(posedge clock);
    #1;
    s_hsel   = 1'b0;
    s_htrans = 2'b00;
    @(negedge clock);  // T1
    n_checks++;
    if ({m_hsel, m_htrans, m_haddr, m_hwrite, s_hreadyout} !==
        {1'b1, 2'b10, 32'h2000_0010, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL read T1: msel=%b mtrans=%b maddr=%h mwrite=%b rdy=%b, required 1 10 20000010 0 0",
               m_hsel, m_htrans, m_haddr, m_hwrite, s_hreadyout);
    end
    @(negedge clock);  // T2
    n_checks++;
    if ({m_hsel, m_htrans, s_hreadyout} !== {1'b0, 2'b00, 1'b0}) begin
      n_fail++;
      $display("FAIL read T2: msel=%b mtrans=%b rdy=%b, required 0 00 0", m_hsel, m_htrans,
               s_hreadyout);
    end
    @(negedge clock);  // T3
    n_checks++;
    if ({s_hreadyout, s_hresp, s_hrdata} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL read T3: rdy=%b resp=%b rdata=%h, required 1 0 deadbeef", s_hreadyout,
               s_hresp, s_hrdata);
    end
    @(posedge clock);
    #1;
  endtask

  // Selected IDLE/BUSY, and NONSEQ while deselected, must not start anything.
  task automatic test_idle_busy();
    int log0;
    log0 = br_log.size();
    for (int k = 0; k < 6; k++) begin
      s_hsel   = (k < 4);
      s_htrans = (k < 2) ? 2'b00 : (k < 4) ? 2'b01 : 2'b10;
      s_haddr  = $urandom;
      @(negedge clock);
      n_checks++;
      if ({s_hreadyout, s_hresp, m_htrans, s_hrdata} !== {1'b1, 1'b0, 2'b00, 32'hDEAD_BEEF}) begin
        n_fail++;
        $display("FAIL idle/busy[%0d]: rdy=%b resp=%b mtrans=%b rdata=%h, required 1 0 00 deadbeef",
                 k, s_hreadyout, s_hresp, m_htrans, s_hrdata);
      end
      @(posedge clock);
      #1;
    end
    idle_inputs();
    @(negedge clock);
    n_checks++;
    if (br_log.size() !== log0) begin
      n_fail++;
      $display("FAIL idle/busy bridge count: got %0d, required %0d", br_log.size(), log0);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_write_waits();
    xq.delete();
    xq.push_back(mk(32'h2000_0004, 1'b1, 32'h1234_5678, 1'b0, 3, 1'b0));
    run_seq("write_waits");
  endtask

  task automatic test_back_to_back();
    xq.delete();
    for (int i = 0; i < 4; i++) xq.push_back(mk(32'h100 + 32'(4 * i), 1'b0, 32'h0, i > 0, 0, 1'b0));
    s_hburst = 3'b011;
    run_seq("incr4");
    s_hburst = 3'b000;
  endtask

  task automatic test_error();
    xq.delete();
    xq.push_back(mk(32'h200, 1'b0, 32'h0, 1'b0, 0, 1'b1));
    xq.push_back(mk(32'h204, 1'b0, 32'h0, 1'b0, 0, 1'b0));
    xq.push_back(mk(32'h208, 1'b1, 32'hCAFE_0001, 1'b0, 2, 1'b1));
    xq.push_back(mk(32'h208, 1'b0, 32'h0, 1'b0, 1, 1'b0));
    run_seq("error");
  endtask

  // Master cancels its pending NONSEQ with IDLE as soon as it sees the first ERROR cycle.
  task automatic test_error_cancel();
    int   log0;
    logic saw;
    log0 = br_log.size();
    saw  = 1'b0;
    br_cfg_q.push_back('{1, 1'b1});
    s_hsel   = 1'b1;
    s_htrans = 2'b10;
    s_haddr  = 32'h50;
    s_hwrite = 1'b0;
    @(posedge clock);
    #1;
    s_haddr = 32'h80;
    for (int c = 0; c < 32; c++) begin
      @(negedge clock);
      if (s_hreadyout === 1'b1) break;
      if (s_hresp === 1'b1) begin
        saw      = 1'b1;
        s_htrans = 2'b00;
      end
    end
    n_checks++;
    if ({saw, s_hreadyout, s_hresp} !== 3'b111) begin
      n_fail++;
      $display("FAIL err_cancel ERR1/ERR2: saw=%b rdy=%b resp=%b, required 1 1 1", saw,
               s_hreadyout, s_hresp);
    end
    @(posedge clock);
    #1;
    idle_inputs();
    repeat (3) @(negedge clock);
    n_checks++;
    if ({br_log.size() - log0, s_hreadyout, s_hresp, m_htrans} !== {32'd1, 1'b1, 1'b0, 2'b00})
    begin
      n_fail++;
      $display("FAIL err_cancel after: xfers=%0d rdy=%b resp=%b mtrans=%b, required 1 1 0 00",
               br_log.size() - log0, s_hreadyout, s_hresp, m_htrans);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_random();
    xfer_t x;
    xq.delete();
    for (int i = 0; i < 24; i++) begin
      x       = mk(32'h1000 + 32'(4 * $urandom_range(0, 7)), 1'($urandom), $urandom,
                   (i > 0) && 1'($urandom), int'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0));
      x.size  = 3'($urandom_range(0, 2));
      x.prot  = 4'($urandom);
      x.lock  = 1'($urandom);
      xq.push_back(x);
    end
    run_seq("random");
  endtask

  task automatic test_reset_mid();
    br_cfg_q.push_back('{5, 1'b0});
    s_hsel   = 1'b1;
    s_htrans = 2'b10;
    s_haddr  = 32'h3000_0000;
    s_hwrite = 1'b1;
    @(posedge clock);
    #1;
    s_hsel   = 1'b0;
    s_htrans = 2'b00;
    s_hwdata = 32'h7777_0000;
    @(negedge clock);
    @(negedge clock);  // DATA, bridge stalling
    n_checks++;
    if ({s_hreadyout, m_htrans, m_hwdata} !== {1'b0, 2'b00, 32'h7777_0000}) begin
      n_fail++;
      $display("FAIL reset_mid pre: rdy=%b mtrans=%b mwdata=%h, required 0 00 77770000",
               s_hreadyout, m_htrans, m_hwdata);
    end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({s_hreadyout, s_hresp, s_hrdata, m_hsel, m_htrans, m_haddr, m_hwrite, m_hwdata} !==
        {1'b1, 1'b0, 32'h0, 1'b0, 2'b00, 32'h0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_mid values: rdy=%b resp=%b rdata=%h msel=%b mtrans=%b maddr=%h mwdata=%h",
               s_hreadyout, s_hresp, s_hrdata, m_hsel, m_htrans, m_haddr, m_hwdata);
    end
    br_cfg_q.delete();
    @(negedge clock);
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock);
    #1;
    xq.delete();
    xq.push_back(mk(32'h2000_0010, 1'b0, 32'h0, 1'b0, 1, 1'b0));
    run_seq("after_reset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    test_reset();
    test_single_read();
    test_idle_busy();
    test_write_waits();
    test_back_to_back();
    test_error();
    test_error_cancel();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
